// File: rtl/etm_mul_pipe.sv
// etm_mul_pipe: 3-stage Mitchell-based error-tolerant multiplier with a valid/ready handshake.
// Define ETM_EXACT_LOW_EN to add the exact path for operands whose high halves are both zero.
module etm_mul_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] c,
    output logic [CNT_W-1:0]   approx_cnt,
    input  logic               cnt_clr
);

    localparam int H  = WIDTH / 2;
    localparam int KW = (H > 1) ? $clog2(H) : 1;
    localparam int SW = KW + 1;
    localparam int TW = 3 * H + 1;

    function automatic logic [KW-1:0] lead_one(input logic [H-1:0] x);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < H; i++) begin
            if (x[i]) k = KW'(i);
        end
        return k;
    endfunction

    // Mantissa bits below the leading one, left-aligned into an H-bit fraction.
    function automatic logic [H-1:0] frac(input logic [H-1:0] x, input logic [KW-1:0] k);
        logic [2*H-1:0] t;
        t    = {{H{1'b0}}, x};
        t[k] = 1'b0;
        t    = t << (H - int'(k));
        return H'(t);
    endfunction

    logic               adv;

    logic               s1_valid_d, s1_valid_q;
    logic [H-1:0]       s1_ah_d, s1_ah_q;
    logic [H-1:0]       s1_bh_d, s1_bh_q;
    logic [H-1:0]       s1_al_d, s1_al_q;
    logic [H-1:0]       s1_bl_d, s1_bl_q;
    logic [KW-1:0]      s1_kx_d, s1_kx_q;
    logic [KW-1:0]      s1_ky_d, s1_ky_q;
    logic               s1_zero_d, s1_zero_q;

    logic               s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0]   s2_hi_d, s2_hi_q;
    logic [H:0]         s2_sum_d, s2_sum_q;
    logic [SW-1:0]      s2_ksum_d, s2_ksum_q;
    logic               s2_zero_d, s2_zero_q;

    logic [TW-1:0]      mitch_ext;
    logic [WIDTH-1:0]   mitch_lo;

    logic               s3_valid_d, s3_valid_q;
    logic               s3_comp_d, s3_comp_q;
    logic [2*WIDTH-1:0] c_d, c_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

`ifdef ETM_EXACT_LOW_EN
    logic               s1_exact_d, s1_exact_q;
    logic               s2_exact_d, s2_exact_q;
    logic [WIDTH-1:0]   s2_lo_exact_d, s2_lo_exact_q;
`endif

    // Global stall: every stage moves together whenever the output slot can drain.
    assign adv        = !s3_valid_q || out_ready;
    assign in_ready   = adv;
    assign out_valid  = s3_valid_q;
    assign c          = c_q;
    assign approx_cnt = cnt_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ah_d    = s1_ah_q;
        s1_bh_d    = s1_bh_q;
        s1_al_d    = s1_al_q;
        s1_bl_d    = s1_bl_q;
        s1_kx_d    = s1_kx_q;
        s1_ky_d    = s1_ky_q;
        s1_zero_d  = s1_zero_q;
`ifdef ETM_EXACT_LOW_EN
        s1_exact_d = s1_exact_q;
`endif
        if (adv) begin
            s1_valid_d = in_valid;
            s1_ah_d    = a[WIDTH-1:H];
            s1_bh_d    = b[WIDTH-1:H];
            s1_al_d    = a[H-1:0];
            s1_bl_d    = b[H-1:0];
            s1_kx_d    = lead_one(a[H-1:0]);
            s1_ky_d    = lead_one(b[H-1:0]);
            s1_zero_d  = (a[H-1:0] == '0) || (b[H-1:0] == '0);
`ifdef ETM_EXACT_LOW_EN
            s1_exact_d = (a[WIDTH-1:H] == '0) && (b[WIDTH-1:H] == '0);
`endif
        end
    end

    always_comb begin
        s2_valid_d    = s2_valid_q;
        s2_hi_d       = s2_hi_q;
        s2_sum_d      = s2_sum_q;
        s2_ksum_d     = s2_ksum_q;
        s2_zero_d     = s2_zero_q;
`ifdef ETM_EXACT_LOW_EN
        s2_exact_d    = s2_exact_q;
        s2_lo_exact_d = s2_lo_exact_q;
`endif
        if (adv) begin
            s2_valid_d    = s1_valid_q;
            s2_hi_d       = {{H{1'b0}}, s1_ah_q} * {{H{1'b0}}, s1_bh_q};
            s2_sum_d      = {1'b0, frac(s1_al_q, s1_kx_q)} + {1'b0, frac(s1_bl_q, s1_ky_q)};
            s2_ksum_d     = {1'b0, s1_kx_q} + {1'b0, s1_ky_q};
            s2_zero_d     = s1_zero_q;
`ifdef ETM_EXACT_LOW_EN
            s2_exact_d    = s1_exact_q;
            s2_lo_exact_d = {{H{1'b0}}, s1_al_q} * {{H{1'b0}}, s1_bl_q};
`endif
        end
    end

    // A fraction sum that carries into bit H already holds the implicit one, so it shifts once more.
    always_comb begin
        mitch_ext = '0;
        if (s2_sum_q[H]) begin
            mitch_ext = TW'(s2_sum_q) << (int'(s2_ksum_q) + 1);
        end else begin
            mitch_ext = (TW'(s2_sum_q) | (TW'(1) << H)) << s2_ksum_q;
        end
        mitch_lo = s2_zero_q ? '0 : WIDTH'(mitch_ext >> H);
    end

    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_comp_d  = s3_comp_q;
        c_d        = c_q;
        if (adv) begin
            s3_valid_d = s2_valid_q;
`ifdef ETM_EXACT_LOW_EN
            s3_comp_d  = !s2_exact_q;
            c_d        = {s2_hi_q, (s2_exact_q ? s2_lo_exact_q : mitch_lo)};
`else
            s3_comp_d  = 1'b1;
            c_d        = {s2_hi_q, mitch_lo};
`endif
        end
    end

    // Clear wins over a same-cycle count; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s3_valid_q && out_ready && s3_comp_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_ah_q       <= '0;
            s1_bh_q       <= '0;
            s1_al_q       <= '0;
            s1_bl_q       <= '0;
            s1_kx_q       <= '0;
            s1_ky_q       <= '0;
            s1_zero_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_hi_q       <= '0;
            s2_sum_q      <= '0;
            s2_ksum_q     <= '0;
            s2_zero_q     <= 1'b0;
            s3_valid_q    <= 1'b0;
            s3_comp_q     <= 1'b0;
            c_q           <= '0;
            cnt_q         <= '0;
`ifdef ETM_EXACT_LOW_EN
            s1_exact_q    <= 1'b0;
            s2_exact_q    <= 1'b0;
            s2_lo_exact_q <= '0;
`endif
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_ah_q       <= s1_ah_d;
            s1_bh_q       <= s1_bh_d;
            s1_al_q       <= s1_al_d;
            s1_bl_q       <= s1_bl_d;
            s1_kx_q       <= s1_kx_d;
            s1_ky_q       <= s1_ky_d;
            s1_zero_q     <= s1_zero_d;
            s2_valid_q    <= s2_valid_d;
            s2_hi_q       <= s2_hi_d;
            s2_sum_q      <= s2_sum_d;
            s2_ksum_q     <= s2_ksum_d;
            s2_zero_q     <= s2_zero_d;
            s3_valid_q    <= s3_valid_d;
            s3_comp_q     <= s3_comp_d;
            c_q           <= c_d;
            cnt_q         <= cnt_d;
`ifdef ETM_EXACT_LOW_EN
            s1_exact_q    <= s1_exact_d;
            s2_exact_q    <= s2_exact_d;
            s2_lo_exact_q <= s2_lo_exact_d;
`endif
        end
    end

endmodule

// File: tb/tb_etm_mul_pipe.sv
// tb_etm_mul_pipe: directed-vector bench for etm_mul_pipe at WIDTH=16.
// Expectations follow ETM_EXACT_LOW_EN when the bundle is built with it.
module tb_etm_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic [15:0] approx_cnt;
    logic        cnt_clr;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [31:0] vc [4];

    etm_mul_pipe #(.WIDTH(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c          (c),
        .approx_cnt (approx_cnt),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] aa, input logic [15:0] bb);
        in_valid = v;
        a        = aa;
        b        = bb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Composite-path beats advance the saturating count; exact-path beats leave it alone.
    function automatic logic [15:0] bumpCnt(input logic [15:0] cur, input logic [15:0] aa,
                                            input logic [15:0] bb);
`ifdef ETM_EXACT_LOW_EN
        if (aa[15:8] == 8'h00 && bb[15:8] == 8'h00) return cur;
`endif
        return (cur == 16'hFFFF) ? cur : cur + 16'd1;
    endfunction

    task automatic sendOne(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                           input logic [31:0] expc);
        applyStimulus(1'b1, aa, bb);
        #1;
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        checkOutput({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_c"}, c, expc);
        exp_cnt = bumpCnt(exp_cnt, aa, bb);
        tick();
        checkOutput({tag, "_cnt"}, {16'd0, approx_cnt}, {16'd0, exp_cnt});
        checkOutput({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        exp_cnt   = 16'h0000;
        va[0] = 16'h0103; vb[0] = 16'h0105; vc[0] = 32'h0001000E;
        va[1] = 16'h0203; vb[1] = 16'h0103; vc[1] = 32'h00020008;
        va[2] = 16'h0300; vb[2] = 16'h0500; vc[2] = 32'h000F0000;
        va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vc[3] = 32'hFE01FE00;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_c", c, 32'd0);
        checkOutput("rst_cnt", {16'd0, approx_cnt}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

`ifdef ETM_EXACT_LOW_EN
        sendOne("small_exact", 16'h0012, 16'h0034, 32'h000003A8);
`else
        sendOne("small_mitchell", 16'h0012, 16'h0034, 32'h00000380);
`endif
        sendOne("mitchell_3x5", 16'h0103, 16'h0105, 32'h0001000E);
        sendOne("carry_3x3", 16'h0203, 16'h0103, 32'h00020008);
        sendOne("high_only", 16'h0300, 16'h0500, 32'h000F0000);
        sendOne("zero_a", 16'h0000, 16'h1234, 32'h00000000);
        sendOne("all_ones", 16'hFFFF, 16'hFFFF, 32'hFE01FE00);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, va[i], vb[i]);
            #1;
            checkOutput((i < 3) ? "bp_in_ready_open" : "bp_in_ready_closed",
                        {31'd0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_hold_c", c, vc[0]);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("bp_stable_c", c, vc[0]);
            checkOutput("bp_stable_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        for (int i = 1; i < 4; i++) begin
            checkOutput("bp_order_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_order_c", c, vc[i]);
            tick();
        end
        checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) exp_cnt = bumpCnt(exp_cnt, va[i], vb[i]);
        checkOutput("bp_cnt", {16'd0, approx_cnt}, {16'd0, exp_cnt});

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, va[i], vb[i]);
            tick();
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_cnt", {16'd0, approx_cnt}, 32'd0);
        checkOutput("midrst_c", c, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_cnt = 16'h0000;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        applyStimulus(1'b1, 16'h0103, 16'h0105);
        for (int i = 0; i < 65534; i++) tick();
        checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("stream_c", c, 32'h0001000E);
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("stream_drained", {31'd0, out_valid}, 32'd0);
        exp_cnt = 16'hFFFE;
        checkOutput("stream_cnt", {16'd0, approx_cnt}, {16'd0, exp_cnt});
        sendOne("sat_reach", 16'h0103, 16'h0105, 32'h0001000E);
        sendOne("sat_hold", 16'h0203, 16'h0103, 32'h00020008);

        applyStimulus(1'b1, 16'h0300, 16'h0500);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
        checkOutput("clr_valid", {31'd0, out_valid}, 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_cnt = 16'h0000;
        checkOutput("clr_priority_cnt", {16'd0, approx_cnt}, {16'd0, exp_cnt});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
